multiply_sequencer: RTL
=======================

// Module: multiply_sequencer
//
// PURPOSE
//  Multi-cycle unsigned shift-add multiplier engine with a start/done handshake.
//  The controlpath raises start while the datapath presents operands newA/newB.
//  The block runs one add/shift step per cycle and pulses done.
//  It then holds the product for the datapath's output_multiply bus until the next accepted start.
//
// PARAMETERS
//  WIDTH    8   operand width; product is 2*WIDTH bits; step count = WIDTH
//
// PORTS
//  clock        in   1          single clock, all state updates on posedge
//  reset        in   1          synchronous, active-high; dominates every other input
//  start        in   1          request; sampled only in M_IDLE
//  opA          in   WIDTH      multiplicand (newA), sampled with accepted start
//  opB          in   WIDTH      multiplier (newB), sampled with accepted start
//  busy         out  1          high in M_RUN and M_DONE
//  done         out  1          one-cycle pulse, high exactly while in M_DONE
//  product      out  2*WIDTH    registered result (output_multiply)
//
// BEHAVIOUR
//  - Reset (clock edge with reset=1):
//    - state=M_IDLE; product=0; acc=0; mcand=0; mplr=0; count=0.
//    - Outputs after reset: busy=0, done=0.
//  - FSM transitions:
//    - M_IDLE -> M_RUN on start=1. At that edge:
//      - mcand <= {WIDTH'0, opA}; mplr <= opB; acc <= 0; count <= 0.
//    - M_RUN: one step per cycle, every step:
//      - if mplr[0], acc <= acc + mcand (2*WIDTH-bit add; no overflow possible);
//      - mcand <= mcand << 1; mplr <= mplr >> 1; count <= count + 1.
//    - M_RUN -> M_DONE at the edge completing step WIDTH (count==WIDTH-1 before that edge).
//      - product <= final acc at that same edge.
//    - M_DONE -> M_IDLE unconditionally after one cycle.
//  - Latency and step count:
//    - start seen in cycle 0 -> M_RUN in cycles 1..WIDTH -> done=1 in cycle WIDTH+1 (9 for WIDTH=8).
//    - Fixed latency; no early termination.
//    - A zero operand still takes WIDTH steps.
//  - Product visibility: product is updated only on entry to M_DONE.
//    - It keeps its old value during M_RUN.
//    - It holds after M_DONE, indefinitely, until the next completion.
//  - Boundary conditions:
//    - start=1 while in M_RUN or M_DONE is ignored (no restart, no queueing), and opA/opB are not sampled.
//    - A level-held start re-triggers in the M_IDLE cycle after M_DONE.
//      - So back-to-back operations have period WIDTH+2.
//    - Operand changes during M_RUN have no effect; operands are latched at acceptance.
//    - Reset mid-M_RUN or in M_DONE:
//      - state=M_IDLE; product cleared to 0;
//      - no done pulse for the aborted operation.
//    - reset and start high in the same cycle: reset wins, and start is not accepted.
//  - done and busy are decoded from the state register (glitch-free, no combinational path from start).
//
// STRUCTURE
//  - Shared package (constants.sv):
//    - typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mul_state_t.
//    - The enum is visible to the top-level $display (.name) and to controlpath.
//  - Step counter width is $clog2(WIDTH)+1, local to the block.
//  - Single flat module; no sub-module.
//  - controlpath owns start/done; datapath instantiates this block, driving opA/opB from newA/newB.
//
// TESTING
//  1. Reset, then start=1 for one cycle with opA=8'h05, opB=8'h03.
//     -> busy=1 in cycles 1..9; done=1 only in cycle 9; product=16'h000F from cycle 9 on.
//  2. opA=8'hFF, opB=8'hFF -> product=16'hFE01 at done; opA=8'h80, opB=8'h02 -> product=16'h0100.
//  3. opA=8'h00, opB=8'hA5 -> done still in cycle 9, product=16'h0000.
//     The previous product is held unchanged in cycles 1..8.
//  4. Case A: start pulses again in cycle 4 with opA=8'h02, opB=8'h02.
//     -> ignored; the first result (5*3=16'h000F) is completed with done in cycle 9.
//     Case B: start held high continuously.
//     -> second done in cycle 19; M_IDLE visited for exactly one cycle (cycle 10).
//  5. Reset asserted in cycle 5 of a run -> M_IDLE, product=0, busy=0 next cycle, no done pulse.
//     A new 7*6 operation then yields 16'h002A.
//  6. Random check: 1000 random opA/opB pairs compared against a golden opA*opB.
//     Each done is exactly WIDTH+1 cycles after acceptance; exactly one done per accepted start.

Source files
------------

// File: rtl/multiply_sequencer_pkg.sv
// Shared definitions for the shift-add multiplier engine.
//   mul_state_t   : sequencer state encoding, visible to the controlpath and
//                   to any top-level debug print that wants the state name.
//   DEFAULT_WIDTH : operand width used when the engine is instantiated
//                   without an override.
package multiply_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        M_IDLE,
        M_RUN,
        M_DONE
    } mul_state_t;

endpackage : multiply_sequencer_pkg

// File: rtl/multiply_sequencer.sv
// Multi-cycle unsigned shift-add multiplier with a start/done handshake.
// One add/shift step per clock, WIDTH steps per operation, then a one-cycle
// done pulse. The product register holds its value until the next completion.
//
// Ports:
//   clock    in   1          single clock, all state updates on posedge
//   reset    in   1          synchronous, active-high; dominates every input
//   start    in   1          request, only looked at while idle
//   opA      in   WIDTH      multiplicand, captured when start is accepted
//   opB      in   WIDTH      multiplier, captured when start is accepted
//   busy     out  1          high while running and during the done cycle
//   done     out  1          one-cycle pulse when the product is updated
//   product  out  2*WIDTH    registered result
module multiply_sequencer
    import multiply_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     opA,
    input  logic [WIDTH-1:0]     opB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int                CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);

    mul_state_t           state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplr;
    logic [CNT_W-1:0]     count;
    logic [2*WIDTH-1:0]   acc_next;

    // Accumulator value after the current step. The final step's sum goes
    // straight into product, so the result is visible on the same edge that
    // enters M_DONE rather than one cycle later.
    assign acc_next = mplr[0] ? (acc + mcand) : acc;

    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= M_IDLE;
            product <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                M_IDLE: begin
                    if (start) begin
                        mcand <= {{WIDTH{1'b0}}, opA};
                        mplr  <= opB;
                        acc   <= '0;
                        count <= '0;
                        state <= M_RUN;
                        busy  <= 1'b1;
                    end
                end

                M_RUN: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    count <= count + CNT_W'(1);
                    if (count == LAST_STEP) begin
                        product <= acc_next;
                        state   <= M_DONE;
                        done    <= 1'b1;
                    end
                end

                M_DONE: begin
                    // Always spend exactly one cycle here; a held start is
                    // picked up again from M_IDLE on the following cycle.
                    state <= M_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end

                default: begin
                    state <= M_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule : multiply_sequencer
